wall_draw: RTL

- Downstream of the wall datapath; converts its wall position (x, top of hole) into VGA pixel writes on the 160x120 screen.
- On each start pulse, erases the previously drawn wall rectangle, then draws the new column with its hole, one pixel per clock.
- Output feeds the VGA adapter plot/x/y/colour inputs directly.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/wall_pixel_sweep.sv | 71 +++++++
 rtl/wall_draw.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Constants shared by the wall datapath and the wall drawer.
//                This covers screen geometry, colours, wall geometry and the
//                state encoding of the draw sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Visible screen geometry, in pixels.
    localparam int unsigned c_SCREEN_W     = 160;
    localparam int unsigned c_SCREEN_H     = 120;

    // Wall geometry. The wall datapath uses the same values.
    localparam int unsigned c_WALL_WIDTH   = 4;
    localparam int unsigned c_HOLE_HEIGHT  = 50;
    // Column where a wall re-enters on the right. It is just off-screen.
    localparam int unsigned c_WALL_RESET_X = 160;

    // 3-bit RGB colours.
    localparam logic [2:0]  c_BG_COLOUR    = 3'b000;
    localparam logic [2:0]  c_WALL_COLOUR  = 3'b010;
    localparam logic [2:0]  c_LIP_COLOUR   = 3'b110;

    // Phases of the draw sequencer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

    // Half-open interval test lo <= v < hi. All operands are 9 bits wide, so
    // a hole that extends below the bottom row cannot wrap to the top.
    function automatic logic in_band(input logic [8:0] v,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wall_pixel_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : wall_pixel_sweep
//  Description : Column-major pixel address generator for a wall strip.
//                The row counter y runs 0..SCREEN_H-1. When y wraps, the
//                column offset dx advances, up to WALL_WIDTH-1. last_o flags
//                the final pixel of the strip.
//  Revision    : 1.0 - initial release
// ============================================================================
module wall_pixel_sweep #(
    parameter int unsigned WALL_WIDTH = 4,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned DX_W       = 2,
    parameter int unsigned Y_W        = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            en_i,
    output logic [DX_W-1:0] dx_o,
    output logic [Y_W-1:0]  y_o,
    output logic            last_o
);

    logic [DX_W-1:0] dx_q;
    logic [DX_W-1:0] dx_d;
    logic [Y_W-1:0]  y_q;
    logic [Y_W-1:0]  y_d;
    logic            col_end;
    logic            dx_end;

    // Detect the end of the current column and of the whole strip.
    always_comb begin
        col_end = (y_q == Y_W'(SCREEN_H - 1));
        dx_end  = (dx_q == DX_W'(WALL_WIDTH - 1));
        last_o  = col_end && dx_end;
    end

    // Compute the next address. A clear overrides the advance.
    always_comb begin
        dx_d = dx_q;
        y_d  = y_q;
        if (clear_i) begin
            dx_d = '0;
            y_d  = '0;
        end else if (en_i) begin
            if (col_end) begin
                y_d  = '0;
                dx_d = dx_end ? '0 : dx_q + DX_W'(1);
            end else begin
                y_d  = y_q + Y_W'(1);
            end
        end
    end

    // Address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_q <= '0;
            y_q  <= '0;
        end else begin
            dx_q <= dx_d;
            y_q  <= y_d;
        end
    end

    assign dx_o = dx_q;
    assign y_o  = y_q;

endmodule
`default_nettype wire

// File: rtl/wall_draw.sv
`default_nettype none
// ============================================================================
//  Module      : wall_draw
//  Description : Converts the wall position (left column and top of the hole)
//                into VGA pixel writes on a 160x120 screen. Each start pulse
//                does two things, one pixel per clock:
//                  1. Erase the wall rectangle drawn last time.
//                  2. Draw the new wall column with its hole.
//                Columns at or beyond the screen width are clipped: no write
//                strobe is issued for them, but the timing does not change.
//                Optional build macro WALL_DRAW_HOLE_LIP_EN adds a row of
//                LIP_COLOUR directly above and directly below the hole.
//  Revision    : 1.0 - initial release
// ============================================================================
module wall_draw
    import game_pkg::*;
#(
`ifdef WALL_DRAW_HOLE_LIP_EN
    parameter logic [2:0]  LIP_COLOUR  = c_LIP_COLOUR,
`endif
    parameter int unsigned WALL_WIDTH  = c_WALL_WIDTH,
    parameter int unsigned SCREEN_W    = c_SCREEN_W,
    parameter int unsigned SCREEN_H    = c_SCREEN_H,
    parameter int unsigned HOLE_HEIGHT = c_HOLE_HEIGHT,
    parameter logic [2:0]  WALL_COLOUR = c_WALL_COLOUR,
    parameter logic [2:0]  BG_COLOUR   = c_BG_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wall_x,
    input  logic [7:0] hole_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
    localparam int unsigned Y_W  = 7;

    draw_state_t     state_q;
    logic [7:0]      cur_x_q;
    logic [7:0]      cur_hy_q;
    logic [7:0]      prev_x_q;
    logic            prev_valid_q;
    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      colour_q;
    logic            plot_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      vga_x_d;
    logic [6:0]      vga_y_d;
    logic [2:0]      colour_d;
    logic            plot_d;

    logic            sweep_clear;
    logic            sweep_en;
    logic            sweep_last;
    logic [DX_W-1:0] sweep_dx;
    logic [Y_W-1:0]  sweep_y;

    logic [7:0]      base_x;
    logic [8:0]      col_sum;
    logic [8:0]      y_ext;
    logic [8:0]      hole_lo;
    logic [8:0]      hole_hi;

    // One sweep instance serves both the erase pass and the draw pass.
    // The counters are cleared when a start is accepted and again at the
    // boundary between erase and draw.
    always_comb begin
        sweep_clear = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_ERASE) && sweep_last);
        sweep_en    = (state_q == ST_ERASE) || (state_q == ST_DRAW);
    end

    wall_pixel_sweep #(
        .WALL_WIDTH (WALL_WIDTH),
        .SCREEN_H   (SCREEN_H),
        .DX_W       (DX_W),
        .Y_W        (Y_W)
    ) u_sweep (
        .clk     (clk),
        .reset   (reset),
        .clear_i (sweep_clear),
        .en_i    (sweep_en),
        .dx_o    (sweep_dx),
        .y_o     (sweep_y),
        .last_o  (sweep_last)
    );

    // Pixel currently addressed by the sweep: position, clip and colour.
    // The sums are 9 bits wide so that walls near the right edge, and holes
    // near the bottom, never wrap around.
    always_comb begin
        base_x   = (state_q == ST_ERASE) ? prev_x_q : cur_x_q;
        col_sum  = {1'b0, base_x} + 9'(sweep_dx);
        y_ext    = 9'(sweep_y);
        hole_lo  = {1'b0, cur_hy_q};
        hole_hi  = hole_lo + 9'(HOLE_HEIGHT);
        vga_x_d  = col_sum[7:0];
        vga_y_d  = sweep_y;
        plot_d   = (col_sum < 9'(SCREEN_W));
        colour_d = WALL_COLOUR;
        if (state_q == ST_ERASE) begin
            colour_d = BG_COLOUR;
        end else if (in_band(y_ext, hole_lo, hole_hi)) begin
            colour_d = BG_COLOUR;
        end
`ifdef WALL_DRAW_HOLE_LIP_EN
        else if (((cur_hy_q != 8'd0) && ((y_ext + 9'd1) == hole_lo)) ||
                 (y_ext == hole_hi)) begin
            colour_d = LIP_COLOUR;
        end
`endif
    end

    // Sequencer and registered outputs. The pixel outputs always describe
    // the address that the sweep held one cycle earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_x_q      <= 8'd0;
            cur_hy_q     <= 8'd0;
            prev_x_q     <= 8'd0;
            prev_valid_q <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            colour_q     <= BG_COLOUR;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_x_q  <= wall_x;
                        cur_hy_q <= hole_y;
                        busy_q   <= 1'b1;
                        state_q  <= prev_valid_q ? ST_ERASE : ST_DRAW;
                    end
                end
                ST_ERASE: begin
                    vga_x_q  <= vga_x_d;
                    vga_y_q  <= vga_y_d;
                    colour_q <= colour_d;
                    plot_q   <= plot_d;
                    if (sweep_last) begin
                        state_q <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    vga_x_q  <= vga_x_d;
                    vga_y_q  <= vga_y_d;
                    colour_q <= colour_d;
                    plot_q   <= plot_d;
                    if (sweep_last) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    prev_x_q     <= cur_x_q;
                    prev_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vga_x  = vga_x_q;
    assign vga_y  = vga_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire
